// File: rtl/rom_download_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_download_ctrl_if
// Description : Bundle of the HPS ioctl download stream and the ROM write /
//               status outputs of rom_download_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_download_ctrl_if;
   // Host download stream
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   // Write port towards decoder / EPROMs, plus load status
   logic [24:0] DL_ADDR;
   logic [7:0]  DL_DATA;
   logic        DL_WR;
   logic        CORE_RESET;
   logic        ROM_LOADED;
   logic        LOAD_ERR;
   logic [24:0] BYTE_COUNT;

   // Host / environment side
   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait, DL_ADDR, DL_DATA, DL_WR, CORE_RESET, ROM_LOADED,
             LOAD_ERR, BYTE_COUNT
   );

   // Download controller side
   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait, DL_ADDR, DL_DATA, DL_WR, CORE_RESET, ROM_LOADED,
             LOAD_ERR, BYTE_COUNT
   );
endinterface
`default_nettype wire

// File: rtl/rom_download_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rom_download_ctrl
// Description : Sequences the ioctl ROM download into one-cycle EPROM write
//               strobes, throttles the host, validates address order and
//               image length, and holds the core in reset until a good image
//               has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_download_ctrl #(
   parameter int unsigned ROM_SIZE   = 'h58300,
   parameter logic [7:0]  ROM_INDEX  = 8'd0,
   parameter int unsigned GAP_CYCLES = 2
) (
   input wire logic           CLK,
   input wire logic           RESET_N,
   rom_download_ctrl_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_GAP   = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   localparam logic [24:0] c_ROM_SIZE = 25'(ROM_SIZE);
   localparam logic [3:0]  c_GAP      = 4'(GAP_CYCLES);
   localparam logic [24:0] c_CNT_MAX  = '1;

   logic [2:0]  r_state;
   logic [3:0]  r_gap_cnt;
   logic        r_bad;
   logic        r_load_err;
   logic        r_dl_wr;
   logic [24:0] r_dl_addr;
   logic [7:0]  r_dl_data;
   logic [24:0] r_byte_count;

   logic        w_sel;
   logic        w_seq_err;
   logic        w_ovf;

   assign w_sel     = bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
   assign w_seq_err = (bus.ioctl_addr != r_byte_count);
   assign w_ovf     = (bus.ioctl_addr >= c_ROM_SIZE);

   // Download sequencer: state, byte acceptance, throttle counter, validation
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= S_IDLE;
         r_gap_cnt    <= '0;
         r_bad        <= 1'b0;
         r_load_err   <= 1'b0;
         r_dl_wr      <= 1'b0;
         r_dl_addr    <= '0;
         r_dl_data    <= '0;
         r_byte_count <= '0;
      end else begin
         r_dl_wr <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (w_sel) begin
                  r_state      <= S_LOAD;
                  r_byte_count <= '0;
                  r_load_err   <= 1'b0;
                  r_bad        <= 1'b0;
               end
            end
            S_LOAD: begin
               if (bus.ioctl_wr) begin
                  if (w_seq_err || w_ovf) r_bad <= 1'b1;
                  // Out-of-range bytes are counted but never reach the EPROMs
                  if (!w_ovf) begin
                     r_dl_wr   <= 1'b1;
                     r_dl_addr <= bus.ioctl_addr;
                     r_dl_data <= bus.ioctl_dout;
                  end
                  if (r_byte_count != c_CNT_MAX) r_byte_count <= r_byte_count + 25'd1;
               end
               // A byte arriving with the falling select is still taken above
               if (!w_sel) begin
                  r_state <= S_CHECK;
               end else if (bus.ioctl_wr && (c_GAP != 4'd0)) begin
                  r_state   <= S_GAP;
                  r_gap_cnt <= c_GAP;
               end
            end
            S_GAP: begin
               // Host ignored ioctl_wait: the byte is lost, so the image is bad
               if (bus.ioctl_wr) r_bad <= 1'b1;
               if (!w_sel) begin
                  r_state   <= S_CHECK;
                  r_gap_cnt <= '0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 4'd1;
                  if (r_gap_cnt <= 4'd1) r_state <= S_LOAD;
               end
            end
            S_CHECK: begin
               if (!r_bad && (r_byte_count == c_ROM_SIZE)) begin
                  r_state <= S_DONE;
               end else begin
                  r_state    <= S_ERROR;
                  r_load_err <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ioctl_wait = (r_state == S_GAP);
   assign bus.CORE_RESET = (r_state != S_DONE);
   assign bus.ROM_LOADED = (r_state == S_DONE);
   assign bus.LOAD_ERR   = r_load_err;
   assign bus.DL_WR      = r_dl_wr;
   assign bus.DL_ADDR    = r_dl_addr;
   assign bus.DL_DATA    = r_dl_data;
   assign bus.BYTE_COUNT = r_byte_count;

endmodule
`default_nettype wire
